// File: rtl/systolic_feeder.sv
// Operand staging and diagonal skew for an N x N systolic array: buffers one A and
// one B matrix by rows, then streams them as wavefronts with clear/enable/done control.
module systolic_feeder #(
    parameter int BIT_WIDTH = 8,
    parameter int N         = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      ld_valid,
    input  logic                      ld_sel,
    input  logic [$clog2(N)-1:0]      ld_row,
    input  logic [BIT_WIDTH*N-1:0]    ld_data,
    input  logic                      start,
    output logic [BIT_WIDTH*N-1:0]    a_out,
    output logic [BIT_WIDTH*N-1:0]    b_out,
    output logic                      sa_enable,
    output logic                      acc_clear,
    output logic                      busy,
    output logic                      done
);

    localparam int RW = $clog2(N);
    localparam int TW = $clog2(3 * N - 2);
    localparam logic [TW-1:0] T_LAST = TW'(3 * N - 3);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CLEAR  = 2'd1,
        STREAM = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t                 state_r;
    state_t                 state_s;
    logic [TW-1:0]          t_r;
    logic [TW-1:0]          t_s;
    logic [BIT_WIDTH-1:0]   abuf_r [N][N];
    logic [BIT_WIDTH-1:0]   bbuf_r [N][N];
    logic                   load_s;
    logic [BIT_WIDTH*N-1:0] a_s;
    logic [BIT_WIDTH*N-1:0] b_s;
    logic                   sa_enable_s;
    logic                   acc_clear_s;
    logic                   busy_s;
    logic                   done_s;
    int                     k_s;

    // Rows outside the array (only possible when N is not a power of two) are dropped.
    assign load_s = ld_valid && (state_r == IDLE) && (int'(ld_row) < N);

    // Operand buffers: whole-row writes while idle, cleared by reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int r = 0; r < N; r++) begin
                for (int c = 0; c < N; c++) begin
                    abuf_r[r][c] <= '0;
                    bbuf_r[r][c] <= '0;
                end
            end
        end else if (load_s) begin
            for (int m = 0; m < N; m++) begin
                if (ld_sel) begin
                    bbuf_r[ld_row][m] <= ld_data[m*BIT_WIDTH +: BIT_WIDTH];
                end else begin
                    abuf_r[ld_row][m] <= ld_data[m*BIT_WIDTH +: BIT_WIDTH];
                end
            end
        end
    end

    // Next-state and wavefront time counter.
    always_comb begin
        state_s = state_r;
        t_s     = t_r;
        case (state_r)
            IDLE: begin
                t_s = '0;
                if (start) begin
                    state_s = CLEAR;
                end else begin
                    state_s = IDLE;
                end
            end
            CLEAR: begin
                state_s = STREAM;
                t_s     = '0;
            end
            STREAM: begin
                if (t_r == T_LAST) begin
                    state_s = DONE;
                    t_s     = '0;
                end else begin
                    state_s = STREAM;
                    t_s     = t_r + TW'(1);
                end
            end
            DONE: begin
                state_s = IDLE;
                t_s     = '0;
            end
            default: begin
                state_s = IDLE;
                t_s     = '0;
            end
        endcase
    end

    // Output values for the upcoming cycle; lane m carries element k = t - m.
    always_comb begin
        a_s         = '0;
        b_s         = '0;
        k_s         = 0;
        sa_enable_s = (state_s == STREAM);
        acc_clear_s = (state_s == CLEAR);
        busy_s      = (state_s != IDLE);
        done_s      = (state_s == DONE);
        for (int m = 0; m < N; m++) begin
            k_s = int'(t_s) - m;
            if ((state_s == STREAM) && (k_s >= 0) && (k_s < N)) begin
                a_s[m*BIT_WIDTH +: BIT_WIDTH] = abuf_r[m][RW'(k_s)];
                b_s[m*BIT_WIDTH +: BIT_WIDTH] = bbuf_r[RW'(k_s)][m];
            end else begin
                a_s[m*BIT_WIDTH +: BIT_WIDTH] = '0;
                b_s[m*BIT_WIDTH +: BIT_WIDTH] = '0;
            end
        end
    end

    // State, counter and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r   <= IDLE;
            t_r       <= '0;
            a_out     <= '0;
            b_out     <= '0;
            sa_enable <= 1'b0;
            acc_clear <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state_r   <= state_s;
            t_r       <= t_s;
            a_out     <= a_s;
            b_out     <= b_s;
            sa_enable <= sa_enable_s;
            acc_clear <= acc_clear_s;
            busy      <= busy_s;
            done      <= done_s;
        end
    end

endmodule

// File: tb/tb_systolic_feeder.sv
// Self-checking bench for systolic_feeder (N=4): per-cycle scoreboard, spot-check
// table for the skew pattern, and a behavioural systolic array for end-to-end C checks.
module tb_systolic_feeder;

    localparam int BW = 8;
    localparam int N  = 4;
    localparam int W  = BW * N;
    localparam int PL = 3 * N + 1;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         ld_valid = 1'b0;
    logic         ld_sel = 1'b0;
    logic [1:0]   ld_row = 2'd0;
    logic [W-1:0] ld_data = '0;
    logic         start = 1'b0;
    logic [W-1:0] a_out;
    logic [W-1:0] b_out;
    logic         sa_enable;
    logic         acc_clear;
    logic         busy;
    logic         done;

    always #5 clk = ~clk;

    systolic_feeder #(.BIT_WIDTH(BW), .N(N)) dut (
        .clk(clk), .reset(reset), .ld_valid(ld_valid), .ld_sel(ld_sel),
        .ld_row(ld_row), .ld_data(ld_data), .start(start),
        .a_out(a_out), .b_out(b_out), .sa_enable(sa_enable),
        .acc_clear(acc_clear), .busy(busy), .done(done)
    );

    typedef struct packed {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         en;
        logic         clr;
        logic         bsy;
        logic         dn;
    } out_t;

    typedef struct {
        int           t;
        logic [W-1:0] a;
        logic [W-1:0] b;
    } vec_t;

    out_t        exp_q[$];
    vec_t        tbl[5];
    int          n_pass = 0;
    int          n_total = 0;
    int          pos = 0;
    int          done_cnt = 0;
    logic [W-1:0] cap_a [PL];
    logic [W-1:0] cap_b [PL];
    logic        cap_clr [PL];
    logic        cap_dn [PL];
    logic [7:0]  ma [N][N];
    logic [7:0]  mb [N][N];
    logic [7:0]  pa [N][N];
    logic [7:0]  pb [N][N];
    logic [7:0]  pc [N][N];

    task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
        n_total++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    function automatic out_t actual();
        return {a_out, b_out, sa_enable, acc_clear, busy, done};
    endfunction

    function automatic logic [7:0] ain(input int i, input int j);
        if (j == 0) return a_out[i*BW +: BW];
        else return pa[i][j-1];
    endfunction

    function automatic logic [7:0] bin(input int i, input int j);
        if (i == 0) return b_out[j*BW +: BW];
        else return pb[i-1][j];
    endfunction

    function automatic logic [7:0] mm(input int i, input int j);
        logic [7:0] s = 8'd0;
        for (int k = 0; k < N; k++) s = s + 8'(ma[i][k] * mb[k][j]);
        return s;
    endfunction

    function automatic logic [W-1:0] pack_row(input bit sel, input int r);
        logic [W-1:0] v = '0;
        for (int m = 0; m < N; m++) v[m*BW +: BW] = sel ? mb[r][m] : ma[r][m];
        return v;
    endfunction

    // Behavioural output-stationary array: one register per hop east (A) and south (B).
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < N; i++)
                for (int j = 0; j < N; j++) begin
                    pa[i][j] <= 8'd0; pb[i][j] <= 8'd0; pc[i][j] <= 8'd0;
                end
        end else if (acc_clear) begin
            for (int i = 0; i < N; i++)
                for (int j = 0; j < N; j++) pc[i][j] <= 8'd0;
        end else if (sa_enable) begin
            for (int i = 0; i < N; i++)
                for (int j = 0; j < N; j++) begin
                    pc[i][j] <= pc[i][j] + 8'(ain(i, j) * bin(i, j));
                    pa[i][j] <= ain(i, j);
                    pb[i][j] <= bin(i, j);
                end
        end
    end

    // Scoreboard monitor: pops one expected record per cycle while a pass is pending.
    initial begin
        forever begin
            @(negedge clk);
            if (done) done_cnt++;
            if (exp_q.size() != 0) begin
                out_t e;
                e = exp_q.pop_front();
                if (pos < PL) begin
                    cap_a[pos] = a_out; cap_b[pos] = b_out;
                    cap_clr[pos] = acc_clear; cap_dn[pos] = done;
                end
                chk($sformatf("sb_pos%0d", pos), 128'(actual()), 128'(e));
                pos++;
            end
        end
    end

    task automatic push_pass();
        out_t e;
        pos = 0;
        exp_q.push_back({{W{1'b0}}, {W{1'b0}}, 1'b0, 1'b1, 1'b1, 1'b0});
        for (int t = 0; t <= 3 * N - 3; t++) begin
            e = '0;
            e.en = 1'b1; e.bsy = 1'b1;
            for (int m = 0; m < N; m++) begin
                if (t - m >= 0 && t - m <= N - 1) begin
                    e.a[m*BW +: BW] = ma[m][t-m];
                    e.b[m*BW +: BW] = mb[t-m][m];
                end
            end
            exp_q.push_back(e);
        end
        exp_q.push_back({{W{1'b0}}, {W{1'b0}}, 1'b0, 1'b0, 1'b1, 1'b1});
        exp_q.push_back('0);
    endtask

    task automatic load_matrix(input bit sel);
        for (int r = 0; r < N; r++) begin
            ld_valid = 1'b1; ld_sel = sel; ld_row = 2'(r); ld_data = pack_row(sel, r);
            @(posedge clk); #1;
            ld_valid = 1'b0;
        end
    endtask

    // One full pass; optional same-edge A row 2 load, optional mid-pass command injection.
    task automatic run_pass(input int inject_t, input bit sim_load,
                            input logic [W-1:0] sim_data, input bit do_c);
        start = 1'b1;
        if (sim_load) begin
            ld_valid = 1'b1; ld_sel = 1'b0; ld_row = 2'd2; ld_data = sim_data;
            for (int m = 0; m < N; m++) ma[2][m] = sim_data[m*BW +: BW];
        end
        @(posedge clk);
        push_pass();
        #1 start = 1'b0; ld_valid = 1'b0;
        for (int c = 1; c <= 3 * N - 1; c++) begin
            @(posedge clk); #1;
            if (inject_t >= 0 && c == inject_t + 1) begin
                start = 1'b1; ld_valid = 1'b1; ld_sel = 1'b0; ld_row = 2'd0;
                ld_data = {W{1'b1}};
            end else begin
                start = 1'b0; ld_valid = 1'b0;
            end
        end
        @(negedge clk);
        if (do_c) begin
            for (int i = 0; i < N; i++)
                for (int j = 0; j < N; j++)
                    chk($sformatf("c_%0d_%0d", i, j), 128'(pc[i][j]), 128'(mm(i, j)));
        end
        @(posedge clk); #1;
        @(negedge clk);
        @(posedge clk); #1;
    endtask

    task automatic set_skew();
        for (int i = 0; i < N; i++)
            for (int k = 0; k < N; k++) begin
                ma[i][k] = 8'(16 * i + k);
                mb[i][k] = 8'(16 * i + k + 128);
            end
    endtask

    initial begin
        int clr_n;
        int dc0;
        tbl[0] = '{0, 32'h00000000, 32'h00000080};
        tbl[1] = '{1, 32'h00001001, 32'h00008190};
        tbl[2] = '{3, 32'h30211203, 32'h8392A1B0};
        tbl[3] = '{6, 32'h33000000, 32'hB3000000};
        tbl[4] = '{9, 32'h00000000, 32'h00000000};

        // Reset held with random inputs.
        for (int c = 0; c < 3; c++) begin
            ld_valid = 1'($urandom); ld_sel = 1'($urandom); ld_row = 2'($urandom);
            ld_data = W'($urandom); start = 1'($urandom);
            @(negedge clk);
            chk("reset_hold", 128'(actual()), 128'(0));
            @(posedge clk); #1;
        end
        ld_valid = 1'b0; start = 1'b0; ld_data = '0;
        reset = 1'b1;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            chk("after_release", 128'(actual()), 128'(0));
        end
        @(posedge clk); #1;

        // Skew pattern.
        set_skew();
        load_matrix(1'b0);
        load_matrix(1'b1);
        run_pass(-1, 1'b0, '0, 1'b1);
        foreach (tbl[v]) begin
            chk($sformatf("skew_a_t%0d", tbl[v].t), 128'(cap_a[tbl[v].t + 1]), 128'(tbl[v].a));
            chk($sformatf("skew_b_t%0d", tbl[v].t), 128'(cap_b[tbl[v].t + 1]), 128'(tbl[v].b));
        end
        clr_n = 0;
        for (int p = 0; p < PL; p++) clr_n += int'(cap_clr[p]);
        chk("acc_clear_cycles", 128'(clr_n), 128'(1));
        chk("done_after_t9", 128'(cap_dn[3 * N - 1]), 128'(1));

        // End-to-end: identity times B[k][j]=k+j.
        for (int i = 0; i < N; i++)
            for (int k = 0; k < N; k++) begin
                ma[i][k] = (i == k) ? 8'd1 : 8'd0;
                mb[i][k] = 8'(i + k);
            end
        load_matrix(1'b0);
        load_matrix(1'b1);
        run_pass(-1, 1'b0, '0, 1'b1);
        chk("c_ident_2_3", 128'(pc[2][3]), 128'(5));

        // End-to-end: all 2s times all 3s.
        for (int i = 0; i < N; i++)
            for (int k = 0; k < N; k++) begin
                ma[i][k] = 8'd2; mb[i][k] = 8'd3;
            end
        load_matrix(1'b0);
        load_matrix(1'b1);
        run_pass(-1, 1'b0, '0, 1'b1);
        chk("c_const_3_3", 128'(pc[3][3]), 128'(24));

        // start and load at t=5 are ignored; row 0 must survive into the next pass.
        run_pass(5, 1'b0, '0, 1'b1);
        run_pass(-1, 1'b0, '0, 1'b1);
        chk("c_after_ignore", 128'(pc[0][0]), 128'(24));

        // Load of A row 2 on the same edge as start.
        run_pass(-1, 1'b1, 32'h47_46_45_44, 1'b1);

        // Reset mid-STREAM at t=4.
        set_skew();
        load_matrix(1'b0);
        load_matrix(1'b1);
        start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("busy_before_reset", 128'({busy, sa_enable}), 128'(3));
        reset = 1'b0;
        #1;
        chk("outputs_on_reset", 128'(actual()), 128'(0));
        @(posedge clk); #1;
        reset = 1'b1;
        for (int i = 0; i < N; i++)
            for (int k = 0; k < N; k++) begin
                ma[i][k] = 8'd0; mb[i][k] = 8'd0;
            end
        run_pass(-1, 1'b0, '0, 1'b1);
        set_skew();
        load_matrix(1'b0);
        load_matrix(1'b1);
        dc0 = done_cnt;
        run_pass(-1, 1'b0, '0, 1'b1);
        chk("done_once", 128'(done_cnt - dc0), 128'(1));
        chk("sb_drained", 128'(exp_q.size()), 128'(0));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
